// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helper functions for the iterative core.
package aes_pkg;

  localparam int unsigned AES_W = 128;
  localparam int unsigned RC_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } aes_state_e;

  // Round constant for key expansion, valid for rc = 1..10.
  function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
    logic [7:0] r;
    case (rc)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [AES_W-1:0] mix_columns(input logic [AES_W-1:0] s);
    logic [AES_W-1:0] r;
    for (int c = 0; c < 4; c++)
      r[AES_W-1-32*c -: 32] = mix_column(s[AES_W-1-32*c -: 32]);
    return r;
  endfunction

  // State is column-major: byte index = row + 4*col; row r rotates left by r.
  function automatic logic [AES_W-1:0] shift_rows(input logic [AES_W-1:0] s);
    logic [AES_W-1:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[AES_W-1-8*(4*c+row) -: 8] = s[AES_W-1-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, table lookup on one byte.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] sub_c
);

  localparam logic [2047:0] LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  assign sub_c = 8'(LUT >> {~x, 3'b000});

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one reusable round, on-the-fly key schedule, valid/ready I/O.
// Optional round-key observation port enabled by defining AES_RK_TAP_EN.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned NR        = 10,
  parameter int unsigned SBOX_PIPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AES_W-1:0] key,
  input  logic [AES_W-1:0] pt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AES_W-1:0] ct,
  output logic             busy
`ifdef AES_RK_TAP_EN
  ,
  output logic [AES_W-1:0] rk_tap,
  output logic             rk_tap_valid
`endif
);

  localparam logic [RC_W-1:0] NR_L = RC_W'(NR);

  aes_state_e       state_q, state_d;
  logic [AES_W-1:0] st_q, st_d, rk_q, rk_d, ct_d;
  logic [AES_W-1:0] sub_st_q, sub_st_d;
  logic [31:0]      sub_kw_q, sub_kw_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             in_ready_d, out_valid_d, busy_d;

  logic [AES_W-1:0] sbox_st_c, sb_sel, sr, rk_next, rnd;
  logic [31:0]      rot_w, sbox_kw_c, kw_sel, temp, w0, w1, w2, w3;

  for (genvar i = 0; i < 16; i++) begin : g_st_sbox
    aes_sbox u_sbox (.x(st_q[AES_W-1-8*i -: 8]), .sub_c(sbox_st_c[AES_W-1-8*i -: 8]));
  end

  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_kw_sbox
    aes_sbox u_sbox (.x(rot_w[31-8*i -: 8]), .sub_c(sbox_kw_c[31-8*i -: 8]));
  end

  // With the S-box pipe, RUN consumes the values captured in SUB.
  assign sb_sel  = (SBOX_PIPE != 0) ? sub_st_q : sbox_st_c;
  assign kw_sel  = (SBOX_PIPE != 0) ? sub_kw_q : sbox_kw_c;
  assign temp    = kw_sel ^ {rcon(rc_q), 24'h000000};
  assign w0      = rk_q[127:96] ^ temp;
  assign w1      = rk_q[95:64]  ^ w0;
  assign w2      = rk_q[63:32]  ^ w1;
  assign w3      = rk_q[31:0]   ^ w2;
  assign rk_next = {w0, w1, w2, w3};
  assign sr      = shift_rows(sb_sel);
  assign rnd     = ((rc_q != NR_L) ? mix_columns(sr) : sr) ^ rk_next;

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rk_d     = rk_q;
    rc_d     = rc_q;
    sub_st_d = sub_st_q;
    sub_kw_d = sub_kw_q;
    ct_d     = ct;
    if (clear) begin
      state_d = ST_IDLE;
      rc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid && in_ready) begin
          st_d    = pt ^ key;
          rk_d    = key;
          rc_d    = RC_W'(1);
          state_d = (SBOX_PIPE != 0) ? ST_SUB : ST_RUN;
        end
        ST_SUB: begin
          sub_st_d = sbox_st_c;
          sub_kw_d = sbox_kw_c;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          rk_d = rk_next;
          st_d = rnd;
          rc_d = rc_q + RC_W'(1);
          if (rc_q == NR_L) begin
            state_d = ST_DONE;
            ct_d    = rnd;
          end else begin
            state_d = (SBOX_PIPE != 0) ? ST_SUB : ST_RUN;
          end
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_SUB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      st_q      <= '0;
      rk_q      <= '0;
      rc_q      <= '0;
      sub_st_q  <= '0;
      sub_kw_q  <= '0;
      ct        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      rk_q      <= rk_d;
      rc_q      <= rc_d;
      sub_st_q  <= sub_st_d;
      sub_kw_q  <= sub_kw_d;
      ct        <= ct_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

`ifdef AES_RK_TAP_EN
  // Publishes each round key as it is written into rk_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_tap       <= '0;
      rk_tap_valid <= 1'b0;
    end else if (!clear && state_q == ST_RUN) begin
      rk_tap       <= rk_next;
      rk_tap_valid <= 1'b1;
    end else begin
      rk_tap_valid <= 1'b0;
    end
  end
`endif

endmodule
